// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the shared-multiplier scheduler.
package mult_sched_pkg;
    localparam int OPW  = 4;
    localparam int PW   = 8;
    localparam int CNTW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        RESP = 2'd2
    } state_e;
endpackage

// File: rtl/mult_sched_if.sv
// Request/result bundle between the requesters, the scheduler and the result consumer.
interface mult_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]                        req_valid;
    logic [NREQ-1:0]                        req_ready;
    logic [mult_sched_pkg::OPW*NREQ-1:0]    req_x;
    logic [mult_sched_pkg::OPW*NREQ-1:0]    req_y;
    logic                                   res_valid;
    logic                                   res_ready;
    logic [mult_sched_pkg::PW-1:0]          res_data;
    logic [IDW-1:0]                         res_id;
    logic                                   busy;
    logic [mult_sched_pkg::CNTW-1:0]        op_cnt;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy, op_cnt
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_data, res_id, busy, op_cnt
    );
endinterface

// File: rtl/mult_sched_core.sv
// Unsigned 4x4 combinational multiplier: shifted partial products summed into a full 8-bit product.
module main
    import mult_sched_pkg::*;
(
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic [PW-1:0]  o
);
    logic [PW-1:0] pp [OPW];

    generate
        for (genvar gi = 0; gi < OPW; gi++) begin : g_pp
            assign pp[gi] = y[gi] ? (PW'(x) << gi) : '0;
        end
    endgenerate

    always_comb begin
        o = '0;
        for (int i = 0; i < OPW; i++) begin
            o = o + pp[i];
        end
    end
endmodule

// File: rtl/mult_sched_rr_arbiter.sv
// Round-robin grant: first requester after ptr, wrapping modulo N. The pointer is held by the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW:0] idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            // Wrap at N rather than 2^IW so non-power-of-two N never visits ghost indices.
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (en && !found && req[idx[IW-1:0]]) begin
                found                 = 1'b1;
                grant[idx[IW-1:0]]    = 1'b1;
                grant_idx             = idx[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/mult_sched.sv
// Time-shares one 4x4 multiplier among NREQ requesters with round-robin arbitration
// and a single tagged valid/ready result port.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mult_sched_if.slave bus
);
    state_e           state_q, state_d;
    logic [OPW-1:0]   x_q, y_q;
    logic [IDW-1:0]   id_q, ptr_q;
    logic [PW-1:0]    res_data_q;
    logic [IDW-1:0]   res_id_q;
    logic             res_valid_q;
    logic [CNTW-1:0]  op_cnt_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             can_accept;
    logic             take;
    logic [PW-1:0]    core_o;

    // A new operand is only taken when the result slot is free or being freed this cycle.
    assign can_accept = (state_q == IDLE) || ((state_q == RESP) && bus.res_ready);
    assign take       = |grant;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .en        (can_accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    main u_core (
        .x (x_q),
        .y (y_q),
        .o (core_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = take ? MULT : IDLE;
            MULT:    state_d = RESP;
            RESP:    if (bus.res_ready) state_d = take ? MULT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = grant;
        bus.busy      = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            if (take) begin
                x_q   <= bus.req_x[grant_idx*OPW +: OPW];
                y_q   <= bus.req_y[grant_idx*OPW +: OPW];
                id_q  <= grant_idx;
                ptr_q <= grant_idx;
            end
            if (state_q == MULT) begin
                res_data_q  <= core_o;
                res_id_q    <= id_q;
                res_valid_q <= 1'b1;
            end else if ((state_q == RESP) && bus.res_ready) begin
                // Drop valid on every handshake so a back-to-back MULT cycle never re-presents the old product.
                res_valid_q <= 1'b0;
                op_cnt_q    <= op_cnt_q + 1'b1;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.op_cnt    = op_cnt_q;
endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: vector table, scoreboard monitor and hand-written corner sequences.
module tb_mult_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_sched_if #(.NREQ(4), .IDW(2)) bus ();

    mult_sched #(.NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] id;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] prod;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    vec_t vt [8];
    exp_t sb [$];
    int   grant_log [$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;
    bit   rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Scoreboard: push on request handshake, pop and compare on result handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    mon_e.id   = 2'(i);
                    mon_e.data = 8'(bus.req_x[i*4 +: 4]) * 8'(bus.req_y[i*4 +: 4]);
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected actual=%0h required=none", bus.res_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_data", 32'(bus.res_data), 32'(mon_e.data));
                    check("sb_id", 32'(bus.res_id), 32'(mon_e.id));
                    exp_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        sb.delete();
        grant_log.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_slot(input int id, input logic [3:0] x, input logic [3:0] y);
        bus.req_x[id*4 +: 4] = x;
        bus.req_y[id*4 +: 4] = y;
    endtask

    task automatic wait_ready(input int id, output bit got);
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_single(input logic [1:0] id, input logic [3:0] x, input logic [3:0] y,
                             input logic [7:0] prod);
        bit got;
        @(posedge clk);
        #1;
        set_slot(int'(id), x, y);
        bus.req_valid = 4'b0001 << id;
        bus.res_ready = 1'b1;
        wait_ready(int'(id), got);
        if (!got) timeout_fail("single_accept");
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("mult_valid_low", 32'(bus.res_valid), 32'd0);
        check("mult_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("res_valid", 32'(bus.res_valid), 32'd1);
        check("res_data", 32'(bus.res_data), 32'(prod));
        check("res_id", 32'(bus.res_id), 32'(id));
        @(posedge clk);
        #1;
        check("op_cnt", 32'(bus.op_cnt), 32'(exp_cnt));
        check("res_valid_drop", 32'(bus.res_valid), 32'd0);
    endtask

    task automatic run_grants(input int n);
        bit got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (grant_log.size() >= n) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        bus.req_valid = '0;
        if (!got) timeout_fail("grant_count");
    endtask

    task automatic drain();
        bit got = 1'b0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("drain");
        check("drain_op_cnt", 32'(bus.op_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   got;
        int   snap;
        int   id;
        logic [7:0] p;

        vt[0] = '{2'd0, 4'hF, 4'hF, 8'hE1};
        vt[1] = '{2'd1, 4'h9, 4'h7, 8'h3F};
        vt[2] = '{2'd2, 4'h5, 4'h5, 8'h19};
        vt[3] = '{2'd3, 4'h0, 4'hF, 8'h00};
        vt[4] = '{2'd1, 4'hF, 4'h1, 8'h0F};
        vt[5] = '{2'd2, 4'h8, 4'h8, 8'h40};
        vt[6] = '{2'd3, 4'hC, 4'hD, 8'h9C};
        vt[7] = '{2'd0, 4'h1, 4'h1, 8'h01};

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 32'd0);

        // Vector table of single operations, starting with 0xF*0xF from reset.
        for (int k = 0; k < 8; k++) begin
            do_single(vt[k].id, vt[k].x, vt[k].y, vt[k].prod);
            if (k == 0) check("first_op_cnt", 32'(bus.op_cnt), 32'd1);
        end
        drain();

        // Round-robin with all requesters valid from reset.
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 4'(i*3), 4'(i+1));
        bus.req_valid = 4'b1111;
        run_grants(5);
        for (int k = 0; k < 5; k++) begin
            check("rr_order", 32'(grant_log[k]), 32'(k % 4));
        end
        drain();

        // Skip and wrap: pointer left at 2, only requesters 3 and 0 asking.
        do_reset();
        do_single(2'd2, 4'h3, 4'h3, 8'h09);
        grant_log.delete();
        set_slot(0, 4'h2, 4'h3);
        set_slot(3, 4'h4, 4'h4);
        bus.req_valid = 4'b1001;
        run_grants(4);
        check("skip_g0", 32'(grant_log[0]), 32'd3);
        check("skip_g1", 32'(grant_log[1]), 32'd0);
        check("skip_g2", 32'(grant_log[2]), 32'd3);
        check("skip_g3", 32'(grant_log[3]), 32'd0);
        drain();

        // Backpressure in RESP: result must hold and no requester may be granted.
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        set_slot(1, 4'h9, 4'h7);
        bus.req_valid = 4'b0010;
        wait_ready(1, got);
        if (!got) timeout_fail("bp_accept");
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1111;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.res_valid), 32'd1);
            check("bp_data", 32'(bus.res_data), 32'h3F);
            check("bp_id", 32'(bus.res_id), 32'd1);
            check("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        snap = exp_cnt;
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        check("bp_one_hs", 32'(bus.op_cnt), 32'(snap + 1));
        check("bp_release_valid", 32'(bus.res_valid), 32'd0);
        drain();

        // Reset during MULT discards the in-flight product.
        @(posedge clk);
        #1;
        set_slot(2, 4'h5, 4'h5);
        bus.req_valid = 4'b0100;
        wait_ready(2, got);
        if (!got) timeout_fail("rst_accept");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_op_cnt", 32'(bus.op_cnt), 32'd0);
        sb.delete();
        grant_log.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_result", 32'(bus.res_valid), 32'd0);
        end
        set_slot(0, 4'h2, 4'h2);
        set_slot(1, 4'h3, 4'h3);
        bus.req_valid = 4'b0011;
        run_grants(1);
        check("midrst_first_grant", 32'(grant_log[0]), 32'd0);
        drain();

        // Exhaustive operands over random requesters with random result backpressure.
        do_reset();
        rand_rdy = 1'b1;
        for (int pi = 0; pi < 256; pi++) begin
            p  = 8'(pi);
            id = int'($urandom_range(0, 3));
            set_slot(id, p[7:4], p[3:0]);
            bus.req_valid = 4'b0001 << id;
            wait_ready(id, got);
            if (!got) timeout_fail("exh_accept");
            tick();
            bus.req_valid = '0;
        end
        rand_rdy = 1'b0;
        drain();
        check("exh_op_cnt", 32'(bus.op_cnt), 32'd256);
        check("exh_results", 32'(exp_cnt), 32'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
